serial_addsub: RTL and testbench

Bit-serial adder/subtractor for the arithmetic lab-cycle datapath. It takes two WIDTH-bit operands and a mode bit, and processes them LSB-first through a single full adder/subtractor cell. A registered carry/borrow links one bit to the next. It is the sequential counterpart of the combinational adder and subtractor cells: it shares one 1-bit cell over WIDTH cycles and reports completion with a start/done handshake.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/full_addsub_cell.sv | 21 ++
 rtl/serial_addsub.sv | 116 +++++++++++
 tb/tb_serial_addsub.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: controller states
// and the encoding of the mode bit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_addsub_cell.sv
// One-bit full adder / full subtractor. The sum/difference bit is the same
// XOR in both modes; only the carry/borrow term differs, and the borrow is
// the carry majority with the minuend bit inverted.
module full_addsub_cell
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    logic a_eff;

    assign a_eff = (mode == MODE_SUB) ? ~a : a;
    assign s     = a ^ b ^ cin;
    assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are latched on an accepted start and
// processed LSB-first through a single full_addsub_cell, one bit per cycle.
// The result register only changes on completion, so partial sums never
// appear on result.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    // Holds the WIDTH-1 bits produced so far; the final bit is merged in
    // combinationally when the result is captured.
    logic [WIDTH-2:0] sh_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;

    logic             bit_s;
    logic             c_d;
    logic [WIDTH-1:0] full_d;
    logic [WIDTH-2:0] sh_d;

    full_addsub_cell u_cell (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (c_q),
        .mode (mode_q),
        .s    (bit_s),
        .cout (c_d)
    );

    // New bit enters at the MSB; after WIDTH shifts full_d is the whole word.
    assign full_d = {bit_s, sh_q};
    assign sh_d   = full_d[WIDTH-1:1];

    // Controller, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_ADD;
            sh_q     <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_q <= sh_d;
                    c_q  <= c_d;
                    if (cnt_q == LAST) begin
                        result_q <= full_d;
                        carry_q  <= c_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: cell truth table, WIDTH=4 vector table and
// corner sequences, and a randomized WIDTH=8 sweep against a reference model.
module tb_serial_addsub;
    import addsub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, mode4, busy4, done4, carry4;
    logic [3:0] a4, b4, res4;
    logic       start8, mode8, busy8, done8, carry8;
    logic [7:0] a8, b8, res8;
    logic       ca, cb, ccin, cmode, cs, ccout;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .carry(carry4)
    );

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .carry(carry8)
    );

    full_addsub_cell u_cell (
        .a(ca), .b(cb), .cin(ccin), .mode(cmode), .s(cs), .cout(ccout)
    );

    typedef struct {
        logic [7:0] r;
        logic       c;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       m;
        logic [3:0] r;
        logic       c;
    } vec_t;

    exp_t q4[$];
    exp_t q8[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard for the WIDTH=4 instance: pop on every done pulse.
    always @(negedge clk) begin
        if (busy4 && done4) check("busy_done_overlap4", 32'(busy4 & done4), 32'd0);
        if (done4 === 1'b1) begin
            if (q4.size() == 0) check("sb4_unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q4.pop_front();
                check("sb4_result", 32'(res4), 32'(e.r[3:0]));
                check("sb4_carry", 32'(carry4), 32'(e.c));
            end
        end
    end

    // Scoreboard for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (busy8 && done8) check("busy_done_overlap8", 32'(busy8 & done8), 32'd0);
        if (done8 === 1'b1) begin
            if (q8.size() == 0) check("sb8_unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q8.pop_front();
                check("sb8_result", 32'(res8), 32'(e.r));
                check("sb8_carry", 32'(carry8), 32'(e.c));
            end
        end
    end

    // One WIDTH=4 operation from an IDLE negedge, checking busy/done timing.
    task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic m,
                           input logic [3:0] er, input logic ec);
        exp_t e;
        e.r = {4'h0, er};
        e.c = ec;
        a4 = a; b4 = b; mode4 = m; start4 = 1'b1;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        check("busy_after_e0", 32'(busy4), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                check("busy_shift", 32'(busy4), 32'd1);
                check("done_early", 32'(done4), 32'd0);
            end else begin
                check("done_latency", 32'(done4), 32'd1);
                check("busy_in_done", 32'(busy4), 32'd0);
            end
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done4), 32'd0);
    endtask

    function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic m);
        logic [8:0] s;
        exp_t e;
        if (m == MODE_SUB) s = {1'b0, a} - {1'b0, b};
        else               s = {1'b0, a} + {1'b0, b};
        e.r = s[7:0];
        e.c = s[8];
        return e;
    endfunction

    vec_t tbl[6];

    initial begin
        tbl[0] = '{a:4'd5, b:4'd3, m:MODE_ADD, r:4'd8, c:1'b0};
        tbl[1] = '{a:4'hF, b:4'h1, m:MODE_ADD, r:4'h0, c:1'b1};
        tbl[2] = '{a:4'h0, b:4'h0, m:MODE_ADD, r:4'h0, c:1'b0};
        tbl[3] = '{a:4'd7, b:4'd2, m:MODE_SUB, r:4'd5, c:1'b0};
        tbl[4] = '{a:4'd2, b:4'd7, m:MODE_SUB, r:4'hB, c:1'b1};
        tbl[5] = '{a:4'h0, b:4'h1, m:MODE_SUB, r:4'hF, c:1'b1};

        rst = 1'b1;
        start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        ca = 1'b0; cb = 1'b0; ccin = 1'b0; cmode = 1'b0;

        // Cell truth table against integer arithmetic.
        for (int i = 0; i < 16; i++) begin
            int v;
            logic [3:0] iv;
            iv = 4'(i);
            {cmode, ca, cb, ccin} = iv;
            #1;
            if (cmode) v = int'(ca) - int'(cb) - int'(ccin);
            else       v = int'(ca) + int'(cb) + int'(ccin);
            check("cell", 32'({cs, ccout}),
                  32'({v[0], (cmode ? (v < 0) : (v > 1))}));
        end

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_result", 32'(res4), 32'd0);
        check("rst_carry", 32'(carry4), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_op4(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].r, tbl[i].c);

        // start during SHIFT and during DONE must be ignored.
        begin
            exp_t e;
            e.r = 8'd13; e.c = 1'b0;
            a4 = 4'd9; b4 = 4'd4; mode4 = MODE_ADD; start4 = 1'b1;
            q4.push_back(e);
            @(negedge clk); start4 = 1'b0;
            @(negedge clk); start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; mode4 = MODE_SUB;
            @(negedge clk); start4 = 1'b0; check("ign_busy2", 32'(busy4), 32'd1);
            @(negedge clk); check("ign_busy3", 32'(busy4), 32'd1);
            @(negedge clk); check("ign_done", 32'(done4), 32'd1);
            start4 = 1'b1; a4 = 4'd2; b4 = 4'd2; mode4 = MODE_ADD;
            @(negedge clk); start4 = 1'b0;
            check("ign_busy_idle", 32'(busy4), 32'd0);
            check("ign_done_idle", 32'(done4), 32'd0);
            @(negedge clk);
            check("ign_not_queued", 32'(busy4), 32'd0);
            check("ign_hold", 32'(res4), 32'd13);
        end

        // Reset in the 3rd SHIFT cycle aborts; next op starts clean.
        a4 = 4'hF; b4 = 4'hF; mode4 = MODE_ADD; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        check("abort_result", 32'(res4), 32'd0);
        check("abort_carry", 32'(carry4), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done4), 32'd0);
        run_op4(4'd1, 4'd2, MODE_ADD, 4'd3, 1'b0);
        run_op4(4'd7, 4'd9, MODE_ADD, 4'd0, 1'b1);

        // start held high: accepted at E0 and E0+WIDTH+2 only.
        begin
            exp_t e;
            e.r = 8'd4; e.c = 1'b0;
            a4 = 4'd3; b4 = 4'd1; mode4 = MODE_ADD; start4 = 1'b1;
            q4.push_back(e);
            for (int k = 0; k <= 12; k++) begin
                @(negedge clk);
                check("b2b_busy", 32'(busy4), 32'((k < 4) || (k >= 6 && k < 10)));
                check("b2b_done", 32'(done4), 32'((k == 4) || (k == 10)));
                if (k == 1) begin a4 = 4'd6; b4 = 4'd2; mode4 = MODE_SUB; end
                if (k == 5) q4.push_back(e);
                if (k == 11) start4 = 1'b0;
            end
        end

        // WIDTH=8 sweep: fixed corners then random operands.
        for (int i = 0; i < 204; i++) begin
            int t;
            case (i)
                0: begin a8 = 8'hFF; b8 = 8'h01; mode8 = MODE_ADD; end
                1: begin a8 = 8'h00; b8 = 8'h01; mode8 = MODE_SUB; end
                2: begin a8 = 8'h80; b8 = 8'h80; mode8 = MODE_ADD; end
                3: begin a8 = 8'h55; b8 = 8'h55; mode8 = MODE_SUB; end
                default: begin
                    a8 = 8'($urandom_range(0, 255));
                    b8 = 8'($urandom_range(0, 255));
                    mode8 = 1'($urandom_range(0, 1));
                end
            endcase
            q8.push_back(model8(a8, b8, mode8));
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            t = 0;
            while (done8 !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (done8 !== 1'b1) begin
                check("w8_timeout", 32'd1, 32'd0);
                void'(q8.pop_front());
            end else begin
                check("w8_latency", 32'(t), 32'd8);
            end
            @(negedge clk);
        end

        check("sb4_drained", 32'(q4.size()), 32'd0);
        check("sb8_drained", 32'(q8.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
